store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/stbuf_pkg.sv | 19 +
 rtl/stbuf_match.sv | 33 +++
 rtl/store_buffer.sv | 117 +++++++++++
 tb/tb_store_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stbuf_pkg.sv
// Shared types and defaults for the store buffer: entry payload and drain-mode FSM states.
package stbuf_pkg;

    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned AW_DEF    = 32;
    localparam int unsigned DW        = 32;

    // Entry address is held at the default width; instances use AW <= AW_DEF.
    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW-1:0]     data;
    } stbuf_entry_t;

    typedef enum logic {
        NORMAL = 1'b0,
        FLUSH  = 1'b1
    } stbuf_state_e;

endpackage

// File: rtl/stbuf_match.sv
// Word-address compare of a load against every live entry; reports the youngest hit.
module stbuf_match
    import stbuf_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned WW    = AW_DEF - 2,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic [WW-1:0] waddr [DEPTH],
    input  logic [PW-1:0] head,
    input  logic [CW-1:0] count,
    input  logic [WW-1:0] ld_waddr,
    output logic          hit,
    output logic [PW-1:0] hit_idx
);

    // Walk oldest to youngest so the last match found is the youngest one.
    always_comb begin
        logic [PW-1:0] idx;
        hit     = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (waddr[idx] == ld_waddr)) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between MEM stage and data memory; loads take the memory port first.
// Define STBUF_FWD_EN to forward buffered data to hitting loads instead of stalling them.
module store_buffer
    import stbuf_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    output logic          st_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic [31:0]   ld_data,
    output logic          ld_stall,
    input  logic          drain_req,
    output logic          empty,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [AW-1:0] addr,
    output logic [31:0]   wd,
    input  logic [31:0]   rd
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = AW - 2;

    stbuf_entry_t entries_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    stbuf_state_e  state_q;
    stbuf_state_e  state_d;

    logic [WW-1:0] waddr [DEPTH];
    logic          hit;
    logic [PW-1:0] hit_idx;
    logic          push;
    logic          pop;
    logic          mem_rd;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            waddr[i] = entries_q[i].addr[AW-1:2];
        end
    end

    stbuf_match #(
        .DEPTH (DEPTH),
        .WW    (WW)
    ) u_match (
        .waddr    (waddr),
        .head     (head_q),
        .count    (count_q),
        .ld_waddr (ld_addr[AW-1:2]),
        .hit      (hit),
        .hit_idx  (hit_idx)
    );

    // Port arbitration: a load that misses owns memory, otherwise the head drains.
    always_comb begin
        mem_rd   = ld_valid && !hit && !rst;
        pop      = !mem_rd && (count_q != '0) && !rst;
        st_ready = (count_q < CW'(DEPTH)) && (state_q == NORMAL);
        push     = st_valid && st_ready;
        empty    = (count_q == '0);
        MemRead  = mem_rd;
        MemWrite = pop;
        addr     = '0;
        wd       = '0;
        if (mem_rd) begin
            addr = ld_addr;
        end else if (pop) begin
            addr = AW'(entries_q[head_q].addr);
            wd   = entries_q[head_q].data;
        end
        // While stalled the returned data is a don't-care.
        ld_data = (ld_valid && hit) ? entries_q[hit_idx].data : rd;
`ifdef STBUF_FWD_EN
        ld_stall = 1'b0;
`else
        ld_stall = ld_valid && hit;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL: if (drain_req) state_d = FLUSH;
            FLUSH:  if ((count_q == '0) && !drain_req) state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
            if (push) begin
                entries_q[tail_q] <= '{addr: AW_DEF'(st_addr), data: st_data};
                tail_q            <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small word-addressed memory model on the data port.
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        drain_req;
    logic        empty;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;

    logic [31:0] mem [256];
    int total = 0;
    int bad   = 0;

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_stall  (ld_stall),
        .drain_req (drain_req),
        .empty     (empty),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .wd        (wd),
        .rd        (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rd = mem[addr[9:2]];
    always @(posedge clk) begin
        if (MemWrite) mem[addr[9:2]] <= wd;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[0]  <= 32'h1234_5678;
        mem[64] <= 32'h0000_0055;
        mem[12] <= 32'h0000_0077;
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; drain_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ld_stall", 32'(ld_stall), 32'd0);
        chk("rst_memread", 32'(MemRead), 32'd0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_wd", wd, 32'h0);
        chk("rst_ld_data", ld_data, 32'h1234_5678);

        // single store drains the next cycle
        st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hAAAA_0001;
        #2;
        chk("s1_ready", 32'(st_ready), 32'd1);
        adv;
        st_valid = 1'b0;
        #2;
        chk("s1_memwrite", 32'(MemWrite), 32'd1);
        chk("s1_addr", addr, 32'h10);
        chk("s1_wd", wd, 32'hAAAA_0001);
        chk("s1_not_empty", 32'(empty), 32'd0);
        adv;
        #2;
        chk("s1_empty", 32'(empty), 32'd1);
        chk("s1_idle_wr", 32'(MemWrite), 32'd0);
        chk("s1_mem", mem[4], 32'hAAAA_0001);

        // fill while loads own the port, then drain in order
        ld_valid = 1'b1; ld_addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 32'h40 + 32'(4 * i); st_data = 32'hB0 + 32'(i);
            #2;
            chk("fill_ready", 32'(st_ready), 32'd1);
            chk("fill_memread", 32'(MemRead), 32'd1);
            chk("fill_ld_data", ld_data, 32'h55);
            adv;
        end
        st_addr = 32'h50; st_data = 32'hDEAD;
        #2;
        chk("full_ready", 32'(st_ready), 32'd0);
        chk("full_no_wr", 32'(MemWrite), 32'd0);
        adv;
        st_valid = 1'b0; ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("drain_wr", 32'(MemWrite), 32'd1);
            chk("drain_addr", addr, 32'h40 + 32'(4 * i));
            chk("drain_wd", wd, 32'hB0 + 32'(i));
            adv;
        end
        #2;
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_ready", 32'(st_ready), 32'd1);
        chk("fifth_ignored", mem[20], 32'h0);

        // two stores to the same word, youngest must win
        ld_valid = 1'b1; ld_addr = 32'h100;
        st_valid = 1'b1; st_addr = 32'h20; st_data = 32'd1;
        adv;
        st_data = 32'd2;
        adv;
        st_valid = 1'b0; ld_addr = 32'h20;
        #2;
`ifdef STBUF_FWD_EN
        chk("hit1_ld_data", ld_data, 32'd2);
        chk("hit1_stall", 32'(ld_stall), 32'd0);
`else
        chk("hit1_stall", 32'(ld_stall), 32'd1);
`endif
        chk("hit1_memread", 32'(MemRead), 32'd0);
        chk("hit1_memwrite", 32'(MemWrite), 32'd1);
        chk("hit1_wd", wd, 32'd1);
        adv;
        #2;
`ifdef STBUF_FWD_EN
        chk("hit2_ld_data", ld_data, 32'd2);
        chk("hit2_stall", 32'(ld_stall), 32'd0);
`else
        chk("hit2_stall", 32'(ld_stall), 32'd1);
`endif
        chk("hit2_wd", wd, 32'd2);
        adv;
        #2;
        chk("hit3_stall", 32'(ld_stall), 32'd0);
        chk("hit3_memread", 32'(MemRead), 32'd1);
        chk("hit3_ld_data", ld_data, 32'd2);
        adv;
        ld_valid = 1'b0;

        // store and load of the same word in one cycle
        st_valid = 1'b1; st_addr = 32'h30; st_data = 32'd5;
        ld_valid = 1'b1; ld_addr = 32'h30;
        #2;
        chk("same_old_data", ld_data, 32'h77);
        chk("same_stall", 32'(ld_stall), 32'd0);
        chk("same_memread", 32'(MemRead), 32'd1);
        adv;
        st_valid = 1'b0;
        #2;
        chk("next_memwrite", 32'(MemWrite), 32'd1);
        chk("next_wd", wd, 32'd5);
`ifdef STBUF_FWD_EN
        chk("next_ld_data", ld_data, 32'd5);
        chk("next_stall", 32'(ld_stall), 32'd0);
`else
        chk("next_stall", 32'(ld_stall), 32'd1);
`endif
        adv;
        #2;
        chk("after_stall", 32'(ld_stall), 32'd0);
        chk("after_ld_data", ld_data, 32'd5);
        chk("after_memread", 32'(MemRead), 32'd1);
        adv;
        ld_valid = 1'b0;

        // drain request with three entries buffered
        ld_valid = 1'b1; ld_addr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = 32'h60 + 32'(4 * i); st_data = 32'(i + 1);
            adv;
        end
        st_valid = 1'b0; ld_valid = 1'b0; drain_req = 1'b1;
        #2;
        chk("fl0_memwrite", 32'(MemWrite), 32'd1);
        chk("fl0_addr", addr, 32'h60);
        adv;
        #2;
        chk("fl1_ready", 32'(st_ready), 32'd0);
        chk("fl1_addr", addr, 32'h64);
        adv;
        #2;
        chk("fl2_ready", 32'(st_ready), 32'd0);
        chk("fl2_addr", addr, 32'h68);
        adv;
        #2;
        chk("fl3_empty", 32'(empty), 32'd1);
        chk("fl3_ready", 32'(st_ready), 32'd0);
        chk("fl3_no_wr", 32'(MemWrite), 32'd0);
        drain_req = 1'b0;
        #2;
        chk("fl4_ready", 32'(st_ready), 32'd0);
        adv;
        #2;
        chk("fl5_ready", 32'(st_ready), 32'd1);

        // reset with two entries pending discards them
        ld_valid = 1'b1; ld_addr = 32'h100;
        st_valid = 1'b1; st_addr = 32'h70; st_data = 32'd9;
        adv;
        st_addr = 32'h74; st_data = 32'd10;
        adv;
        ld_valid = 1'b0;
        st_addr = 32'h80; st_data = 32'd11;
        drain_req = 1'b1;
        rst = 1'b1;
        #2;
        chk("rst2_no_wr", 32'(MemWrite), 32'd0);
        adv;
        rst = 1'b0; st_valid = 1'b0; drain_req = 1'b0;
        #2;
        chk("rst2_empty", 32'(empty), 32'd1);
        chk("rst2_ready", 32'(st_ready), 32'd1);
        chk("rst2_no_wr_after", 32'(MemWrite), 32'd0);
        chk("rst2_addr", addr, 32'h0);
        adv;
        #2;
        chk("rst2_idle_wr", 32'(MemWrite), 32'd0);
        chk("rst2_mem70", mem[28], 32'h0);
        chk("rst2_mem74", mem[29], 32'h0);
        chk("rst2_mem80", mem[32], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
